// File: rtl/regincr_pipe_pkg.sv
// Shared types and constants for the pipelined registered incrementer.
// Holds the per-stage sideband payload and the default-configuration totals.
package regincr_pipe_pkg;

    localparam int unsigned DEF_NBITS     = 8;
    localparam int unsigned DEF_NSTAGES   = 2;
    localparam int unsigned DEF_INC       = 1;
    localparam int unsigned DEF_CNT_NBITS = 16;

    // Sideband carried with every message: mode bit and sticky overflow flag
    typedef struct packed {
        logic sat;
        logic ovf;
    } side_t;

    localparam int unsigned SIDE_NBITS = $bits(side_t);

    function automatic int unsigned total_inc(input int unsigned nstages,
                                              input int unsigned inc);
        return nstages * inc;
    endfunction

    localparam int unsigned TOTAL_INC = DEF_NSTAGES * DEF_INC;

endpackage

// File: rtl/regincr_pipe_if.sv
// Valid/ready stream bundle for the incrementer pipe: input side and output side.
// The DUT uses the slave view; the producer/consumer uses the master view.
interface regincr_pipe_if
    import regincr_pipe_pkg::*;
#(
    parameter int unsigned p_nbits = DEF_NBITS
);
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in_msg;
    logic               in_sat;
    logic               out_val;
    logic               out_rdy;
    logic [p_nbits-1:0] out_msg;
    logic               out_ovf;

    modport master (
        output in_val, in_msg, in_sat, out_rdy,
        input  in_rdy, out_val, out_msg, out_ovf
    );

    modport slave (
        input  in_val, in_msg, in_sat, out_rdy,
        output in_rdy, out_val, out_msg, out_ovf
    );
endinterface

// File: rtl/regincr_pipe_stage.sv
// One elastic pipeline stage: val/msg/side registers plus an incrementer that
// wraps or saturates according to the mode bit travelling with the message.
module regincr_pipe_stage
    import regincr_pipe_pkg::*;
#(
    parameter int unsigned p_nbits = DEF_NBITS,
    parameter int unsigned p_inc   = DEF_INC
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               rdy,
    input  logic               prev_val,
    input  logic [p_nbits-1:0] prev_msg,
    input  side_t              prev_side,
    output logic               val,
    output logic [p_nbits-1:0] msg,
    output side_t              side
);
    localparam logic [p_nbits:0] INC = (p_nbits+1)'(p_inc);

    logic [p_nbits:0]   sum;
    logic               carry;
    logic [p_nbits-1:0] next_msg;

    assign sum      = {1'b0, prev_msg} + INC;
    assign carry    = sum[p_nbits];
    assign next_msg = (carry && prev_side.sat) ? '1 : sum[p_nbits-1:0];

    // rdy means this stage is empty or its contents leave this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val  <= 1'b0;
            msg  <= '0;
            side <= '0;
        end else if (rdy) begin
            val <= prev_val;
            if (prev_val) begin
                msg      <= next_msg;
                side.sat <= prev_side.sat;
                side.ovf <= prev_side.ovf | carry;
            end
        end
    end
endmodule

// File: rtl/regincr_pipe.sv
// Multi-stage registered incrementer with valid/ready handshakes.
// Owns the ready chain, the stage replication and the completed-transfer counter.
module regincr_pipe
    import regincr_pipe_pkg::*;
#(
    parameter int unsigned p_nbits     = DEF_NBITS,
    parameter int unsigned p_nstages   = DEF_NSTAGES,
    parameter int unsigned p_inc       = DEF_INC,
    parameter int unsigned p_cnt_nbits = DEF_CNT_NBITS
)(
    input  logic                   clk,
    input  logic                   reset,
    regincr_pipe_if.slave          bus,
    output logic [p_cnt_nbits-1:0] count
);
    // Index 0 is the input port; index k+1 is the register set of stage k
    logic [p_nstages:0]              val_c;
    logic [p_nstages:0][p_nbits-1:0] msg_c;
    side_t [p_nstages:0]             side_c;
    logic [p_nstages-1:0]            rdy_c;
    logic                            unused_sat;

    assign val_c[0]      = bus.in_val;
    assign msg_c[0]      = bus.in_msg;
    assign side_c[0].sat = bus.in_sat;
    assign side_c[0].ovf = 1'b0;

    // Stage k may capture when it is empty or everything downstream moves
    always_comb begin
        logic r;
        r     = bus.out_rdy;
        rdy_c = '0;
        for (int k = int'(p_nstages) - 1; k >= 0; k--) begin
            r        = !val_c[k+1] || r;
            rdy_c[k] = r;
        end
    end

    for (genvar k = 0; k < p_nstages; k++) begin : g_stage
        regincr_pipe_stage #(
            .p_nbits (p_nbits),
            .p_inc   (p_inc)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .rdy       (rdy_c[k]),
            .prev_val  (val_c[k]),
            .prev_msg  (msg_c[k]),
            .prev_side (side_c[k]),
            .val       (val_c[k+1]),
            .msg       (msg_c[k+1]),
            .side      (side_c[k+1])
        );
    end

    assign bus.in_rdy  = !reset && rdy_c[0];
    assign bus.out_val = val_c[p_nstages];
    assign bus.out_msg = msg_c[p_nstages];
    assign bus.out_ovf = side_c[p_nstages].ovf;
    assign unused_sat  = side_c[p_nstages].sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (bus.out_val && bus.out_rdy) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_regincr_pipe.sv
// Bench for regincr_pipe: directed scenarios on the default and a 4-bit/3-stage
// configuration, plus random handshakes scored against an arithmetic model.
module tb_regincr_pipe;
    import regincr_pipe_pkg::*;

    localparam int unsigned NB_A = 8;
    localparam int unsigned NB_B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] cnta_m = '0;
    logic [15:0] cntb_m = '0;

    logic [7:0]  nxt;
    int          acc;
    logic        rdy_s;
    logic [15:0] c0;

    regincr_pipe_if #(.p_nbits(NB_A)) ifa ();
    regincr_pipe_if #(.p_nbits(NB_B)) ifb ();

    regincr_pipe #(.p_nbits(NB_A), .p_nstages(2), .p_inc(1), .p_cnt_nbits(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .count(cnt_a));

    regincr_pipe #(.p_nbits(NB_B), .p_nstages(3), .p_inc(5), .p_cnt_nbits(16)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .count(cnt_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Whole-pipe behaviour: the sum of all stage increments, flagged if it ever
    // left the range; saturation pins the result to all-ones once that happens.
    function automatic logic [31:0] model_out(input int unsigned m, input bit s,
                                              input int unsigned nbits, input int unsigned total);
        int unsigned lim;
        int unsigned sum;
        int unsigned res;
        bit          ovf;
        lim = 32'd1 << nbits;
        sum = m + total;
        ovf = (sum >= lim);
        res = (ovf && s) ? lim - 1 : sum % lim;
        return res | (32'(ovf) << nbits);
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            qa.delete();
            cnta_m = '0;
        end else begin
            check("cnt_a", 32'(cnt_a), 32'(cnta_m));
            if (ifa.out_val && ifa.out_rdy) begin
                check("sb_a_nonempty", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    check("sb_a_msg", 32'(ifa.out_msg), e & 32'hFF);
                    check("sb_a_ovf", 32'(ifa.out_ovf), (e >> NB_A) & 32'd1);
                end
                cnta_m = cnta_m + 16'd1;
            end
            if (ifa.in_val && ifa.in_rdy)
                qa.push_back(model_out(32'(ifa.in_msg), ifa.in_sat, NB_A, TOTAL_INC));
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            qb.delete();
            cntb_m = '0;
        end else begin
            check("cnt_b", 32'(cnt_b), 32'(cntb_m));
            if (ifb.out_val && ifb.out_rdy) begin
                check("sb_b_nonempty", 32'(qb.size() > 0), 32'd1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    check("sb_b_msg", 32'(ifb.out_msg), e & 32'hF);
                    check("sb_b_ovf", 32'(ifb.out_ovf), (e >> NB_B) & 32'd1);
                end
                cntb_m = cntb_m + 16'd1;
            end
            if (ifb.in_val && ifb.in_rdy)
                qb.push_back(model_out(32'(ifb.in_msg), ifb.in_sat, NB_B, total_inc(3, 5)));
        end
    end

    task automatic send_a(input logic [7:0] m, input logic s);
        ifa.in_val = 1'b1; ifa.in_msg = m; ifa.in_sat = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifa.in_rdy) break;
        end
        check("send_a_rdy", 32'(ifa.in_rdy), 32'd1);
        @(posedge clk); #1;
        ifa.in_val = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] m, input logic s);
        ifb.in_val = 1'b1; ifb.in_msg = m; ifb.in_sat = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifb.in_rdy) break;
        end
        check("send_b_rdy", 32'(ifb.in_rdy), 32'd1);
        @(posedge clk); #1;
        ifb.in_val = 1'b0;
    endtask

    task automatic expect_out_a(input string tag, input logic [7:0] m, input logic o);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.out_val) break;
        end
        check({tag, "_val"}, 32'(ifa.out_val), 32'd1);
        check({tag, "_msg"}, 32'(ifa.out_msg), 32'(m));
        check({tag, "_ovf"}, 32'(ifa.out_ovf), 32'(o));
        @(posedge clk); #1;
    endtask

    task automatic expect_out_b(input string tag, input logic [3:0] m, input logic o);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.out_val) break;
        end
        check({tag, "_val"}, 32'(ifb.out_val), 32'd1);
        check({tag, "_msg"}, 32'(ifb.out_msg), 32'(m));
        check({tag, "_ovf"}, 32'(ifb.out_ovf), 32'(o));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ifa.in_val = 1'b0; ifa.in_msg = '0; ifa.in_sat = 1'b0; ifa.out_rdy = 1'b0;
        ifb.in_val = 1'b0; ifb.in_msg = '0; ifb.in_sat = 1'b0; ifb.out_rdy = 1'b0;
        #1;
        check("rst_in_rdy",  32'(ifa.in_rdy),  32'd0);
        check("rst_out_val", 32'(ifa.out_val), 32'd0);
        check("rst_out_msg", 32'(ifa.out_msg), 32'd0);
        check("rst_out_ovf", 32'(ifa.out_ovf), 32'd0);
        check("rst_count",   32'(cnt_a),       32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rel_in_rdy", 32'(ifa.in_rdy), 32'd1);
        @(posedge clk); #1;

        // Basic transfer and latency
        ifa.out_rdy = 1'b1; ifb.out_rdy = 1'b1;
        ifa.in_val = 1'b1; ifa.in_msg = 8'h05; ifa.in_sat = 1'b0;
        @(negedge clk);
        check("basic_in_rdy", 32'(ifa.in_rdy), 32'd1);
        @(posedge clk); #1;
        ifa.in_val = 1'b0;
        check("lat_edge0", 32'(ifa.out_val), 32'd0);
        @(posedge clk); #1;
        check("lat_edge1", 32'(ifa.out_val), 32'd1);
        check("basic_msg", 32'(ifa.out_msg), 32'h07);
        check("basic_ovf", 32'(ifa.out_ovf), 32'd0);
        @(posedge clk); #1;
        check("basic_count", 32'(cnt_a), 32'd1);
        check("basic_drained", 32'(ifa.out_val), 32'd0);

        // Wrap and saturate corners
        send_a(8'hFF, 1'b0); expect_out_a("wrap_ff", 8'h01, 1'b1);
        send_a(8'hFE, 1'b0); expect_out_a("wrap_fe", 8'h00, 1'b1);
        send_a(8'hFE, 1'b1); expect_out_a("sat_fe",  8'hFF, 1'b1);
        send_a(8'hFD, 1'b1); expect_out_a("sat_fd",  8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: two accepts fill the pipe, then release
        c0 = cnt_a;
        ifa.out_rdy = 1'b0;
        nxt = 8'h10; acc = 0;
        ifa.in_val = 1'b1; ifa.in_msg = nxt; ifa.in_sat = 1'b0;
        for (int cyc = 0; cyc < 40 && acc < 4; cyc++) begin
            if (cyc == 4) begin
                check("bp_accepts", 32'(acc), 32'd2);
                check("bp_full_rdy", 32'(ifa.in_rdy), 32'd0);
                check("bp_full_val", 32'(ifa.out_val), 32'd1);
                ifa.out_rdy = 1'b1;
            end
            @(negedge clk); rdy_s = ifa.in_rdy;
            @(posedge clk); #1;
            if (rdy_s) begin
                acc++; nxt = nxt + 8'd1; ifa.in_msg = nxt;
            end
        end
        ifa.in_val = 1'b0;
        check("bp_all_accepted", 32'(acc), 32'd4);
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", 32'(cnt_a - c0), 32'd4);

        // Asynchronous reset with transactions in flight
        ifa.out_rdy = 1'b0;
        send_a(8'h20, 1'b0);
        send_a(8'h21, 1'b0);
        check("pre_rst_val", 32'(ifa.out_val), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_val", 32'(ifa.out_val), 32'd0);
        check("async_rst_cnt", 32'(cnt_a), 32'd0);
        check("async_rst_rdy", 32'(ifa.in_rdy), 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("post_rst_rdy", 32'(ifa.in_rdy), 32'd1);
        ifa.out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(ifa.out_val), 32'd0);
        end
        check("post_rst_cnt", 32'(cnt_a), 32'd0);
        @(posedge clk); #1;

        // 4-bit, 3-stage, increment 5
        send_b(4'h3, 1'b0); expect_out_b("b_wrap", 4'h2, 1'b1);
        send_b(4'h3, 1'b1); expect_out_b("b_sat",  4'hF, 1'b1);
        send_b(4'h0, 1'b1); expect_out_b("b_nosat", 4'hF, 1'b0);

        // Random handshakes on both configurations
        for (int c = 0; c < 600; c++) begin
            ifa.in_val  = 1'($urandom_range(0, 1));
            ifa.in_msg  = 8'($urandom);
            ifa.in_sat  = 1'($urandom_range(0, 1));
            ifa.out_rdy = ($urandom_range(0, 3) != 0);
            ifb.in_val  = 1'($urandom_range(0, 1));
            ifb.in_msg  = 4'($urandom);
            ifb.in_sat  = 1'($urandom_range(0, 1));
            ifb.out_rdy = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        ifa.in_val = 1'b0; ifa.out_rdy = 1'b1;
        ifb.in_val = 1'b0; ifb.out_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
